// File: rtl/debug_display.sv
// Eight-digit multiplexed seven-segment viewer for processor pc/data/state, with a debounced
// view-select button. Build macro BLANK_LEADING_ZEROS_EN blanks digits above the top non-zero nibble.
module debug_display #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic [31:0] pc,
  input  logic [31:0] data,
  input  logic        view_btn,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  view
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        btn_meta_q, btn_meta_d;
  logic        btn_sync_q, btn_sync_d;
  logic        btn_level_q, btn_level_d;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]  view_q, view_d;

  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic [1:0]  snap_view_q, snap_view_d;
  logic        run_q, run_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [31:0] view_word;
  logic        scan_load;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'h40;
      4'h1:    hex_glyph = 7'h79;
      4'h2:    hex_glyph = 7'h24;
      4'h3:    hex_glyph = 7'h30;
      4'h4:    hex_glyph = 7'h19;
      4'h5:    hex_glyph = 7'h12;
      4'h6:    hex_glyph = 7'h02;
      4'h7:    hex_glyph = 7'h78;
      4'h8:    hex_glyph = 7'h00;
      4'h9:    hex_glyph = 7'h10;
      4'hA:    hex_glyph = 7'h08;
      4'hB:    hex_glyph = 7'h03;
      4'hC:    hex_glyph = 7'h46;
      4'hD:    hex_glyph = 7'h21;
      4'hE:    hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Button path: two-flop synchroniser, then a level that flips only after a full stable window.
  always_comb begin
    btn_meta_d  = view_btn;
    btn_sync_d  = btn_meta_q;
    btn_level_d = btn_level_q;
    deb_cnt_d   = '0;
    view_d      = view_q;
    if (btn_sync_q != btn_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_level_d = btn_sync_q;
        if (btn_sync_q) begin
          view_d = view_q + 2'd1;
        end
      end else begin
        deb_cnt_d = deb_cnt_q + 20'd1;
      end
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + 16'd1;
    idx_d     = idx_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end
  end

  always_comb begin
    case (view_q)
      2'd0:    view_word = pc;
      2'd1:    view_word = data;
      2'd2:    view_word = {28'h0, state};
      default: view_word = {pc[15:0], data[15:0]};
    endcase
  end

  // The whole scan shows one frozen word, so view changes only land at the start of a scan.
  always_comb begin
    scan_load   = (ref_cnt_q == 16'd0) && (idx_q == 3'd0);
    snap_d      = scan_load ? view_word : snap_q;
    snap_view_d = scan_load ? view_q : snap_view_q;
    run_d       = 1'b1;
  end

  assign nibble = snap_d[{idx_q, 2'b00} +: 4];

`ifdef BLANK_LEADING_ZEROS_EN
  logic [7:0] nib_nz;
  logic [2:0] top_idx;

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib_nz
    assign nib_nz[gi] = |snap_d[4*gi +: 4];
  end

  always_comb begin
    top_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nib_nz[i]) begin
        top_idx = 3'(i);
      end
    end
  end

  assign blank = (idx_q > top_idx);
`else
  assign blank = 1'b0;
`endif

  // Outputs stay dark on the first edge after reset while the snapshot is being taken.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (run_q && !blank) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = hex_glyph(nibble);
      dp_d  = !((snap_view_d == 2'd3) && (idx_q == 3'd4));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      view_q      <= 2'd0;
      ref_cnt_q   <= '0;
      idx_q       <= 3'd0;
      snap_q      <= '0;
      snap_view_q <= 2'd0;
      run_q       <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      btn_level_q <= btn_level_d;
      deb_cnt_q   <= deb_cnt_d;
      view_q      <= view_d;
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      snap_view_q <= snap_view_d;
      run_q       <= run_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign view = view_q;

endmodule

// File: tb/tb_debug_display.sv
// Directed bench for debug_display with REFRESH_DIV = 4 and DEBOUNCE_CYCLES = 8.
// Expectations follow BLANK_LEADING_ZEROS_EN when the bench is built with that macro.
module tb_debug_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  state = 4'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] data = 32'h0;
  logic        view_btn = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  view;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  debug_display #(
    .REFRESH_DIV     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .pc       (pc),
    .data     (data),
    .view_btn (view_btn),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .view     (view)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit digit_blank(input logic [31:0] w, input int k);
    int top;
    top = 0;
    for (int i = 1; i < 8; i++) begin
      if (w[4*i +: 4] != 4'h0) top = i;
    end
`ifdef BLANK_LEADING_ZEROS_EN
    return (k > top);
`else
    return (top < 0);
`endif
  endfunction

  task automatic check_digit(input string tag, input logic [31:0] w, input int k, input bit dp4);
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] nib;
    nib = w[4*k +: 4];
    if (digit_blank(w, k)) begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(8'd1 << k);
      e_seg = glyph_tab[nib];
      e_dp  = !(dp4 && (k == 4));
    end
    check_val($sformatf("%s_d%0d_an", tag, k), {24'h0, an}, {24'h0, e_an});
    check_val($sformatf("%s_d%0d_seg", tag, k), {25'h0, seg}, {25'h0, e_seg});
    check_val($sformatf("%s_d%0d_dp", tag, k), {31'h0, dp}, {31'h0, e_dp});
  endtask

  task automatic wait_scan_start(input string tag, output bit ok);
    logic [7:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an == 8'hFE && prev != 8'hFE) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
    if (!ok) check_val({tag, "_sync"}, {24'h0, an}, 32'hFE);
  endtask

  // Checks every digit of one full scan, sampled mid-digit.
  task automatic scan_check(input string tag, input logic [31:0] w, input bit dp4);
    bit ok;
    wait_scan_start(tag, ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        repeat ((k == 0) ? 1 : 4) @(negedge clk);
        check_digit(tag, w, k, dp4);
      end
      $display("scan %s word=%h done", tag, w);
    end
  endtask

  // Changes the viewed input while digit 1 is lit; the rest of the scan must keep the old word.
  task automatic midscan(input string tag, input bit use_pc, input logic [31:0] old_w,
                         input logic [31:0] new_w);
    bit ok;
    if (use_pc) pc = old_w;
    else data = old_w;
    wait_scan_start(tag, ok);
    if (ok) begin
      @(negedge clk);
      check_digit(tag, old_w, 0, 1'b0);
      repeat (3) @(negedge clk);
      if (use_pc) pc = new_w;
      else data = new_w;
      for (int k = 1; k < 8; k++) begin
        repeat ((k == 1) ? 1 : 4) @(negedge clk);
        check_digit(tag, old_w, k, 1'b0);
      end
      $display("midscan %s old=%h new=%h done", tag, old_w, new_w);
      scan_check({tag, "_next"}, new_w, 1'b0);
    end
  endtask

  task automatic press(input int hi_cycles, input logic [1:0] exp_view);
    @(negedge clk);
    view_btn = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    view_btn = 1'b0;
    repeat (20) @(negedge clk);
    check_val($sformatf("press%0d_view", hi_cycles), {30'h0, view}, {30'h0, exp_view});
    $display("press hi=%0d -> view=%0d", hi_cycles, view);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pc = 32'h0040_0010;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_an", {24'h0, an}, 32'hFF);
    check_val("rst_seg", {25'h0, seg}, 32'h7F);
    check_val("rst_dp", {31'h0, dp}, 32'h1);
    check_val("rst_view", {30'h0, view}, 32'h0);

    rst = 1'b1;
    @(negedge clk);
    check_val("rel_e1_an", {24'h0, an}, 32'hFF);
    @(negedge clk);
    check_digit("rel", pc, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_digit("rel", pc, 1, 1'b0);
    for (int k = 2; k < 8; k++) begin
      repeat (4) @(negedge clk);
      check_digit("rel", pc, k, 1'b0);
    end
    $display("reset release scan done");

    midscan("v0_pc", 1'b1, 32'h0040_0010, 32'h8888_8888);

    press(12, 2'd1);
    press(5, 2'd1);
    press(12, 2'd2);
    press(12, 2'd3);
    press(12, 2'd0);
    press(12, 2'd1);
    press(12, 2'd2);
    press(12, 2'd3);

    pc   = 32'h0000_1234;
    data = 32'h0000_ABCD;
    scan_check("v3", 32'h1234_ABCD, 1'b1);

    press(12, 2'd0);
    press(12, 2'd1);
    midscan("v1_data", 1'b0, 32'h0000_0001, 32'h0000_000F);

    @(negedge clk);
    view_btn = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("arst_an", {24'h0, an}, 32'hFF);
    check_val("arst_seg", {25'h0, seg}, 32'h7F);
    check_val("arst_dp", {31'h0, dp}, 32'h1);
    check_val("arst_view", {30'h0, view}, 32'h0);
    view_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("arst_e1_an", {24'h0, an}, 32'hFF);
    @(negedge clk);
    check_val("arst_e2_an", {24'h0, an}, 32'hFE);
    repeat (20) @(negedge clk);
    check_val("arst_after_view", {30'h0, view}, 32'h0);
    $display("async reset during press done");

    press(12, 2'd1);
    press(12, 2'd2);
    state = 4'h5;
    scan_check("v2_state", 32'h0000_0005, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_display.md
DEBUG_DISPLAY -- requirements
Module: debug_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit is driven; legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning cycles the button must be stable before a level is accepted; legal range 2..2^20-1.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port state, input, 4, meaning the processor control FSM state.
REQ-006 SHALL have port pc, input, 32, meaning the processor current PC.
REQ-007 SHALL have port data, input, 32, meaning the processor debug data word.
REQ-008 SHALL have port view_btn, input, 1, meaning raw asynchronous view-select pushbutton (1 = pressed).
REQ-009 SHALL have port an, output, 8, meaning digit enables, active-low, bit 0 = rightmost digit.
REQ-010 SHALL have port seg, output, 7, meaning cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1, meaning decimal point, active-low.
REQ-012 SHALL have port view, output, 2, meaning current view selection.

Function
REQ-013 SHALL synchronise view_btn through two flops before any use.
REQ-014 SHALL accept a new debounced level only after the synchronised input differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level clears the count.
REQ-015 SHALL increment view by 1 on each 0->1 transition of the accepted level, wrapping 3->0; release does not change view.
REQ-016 SHALL map views: 0 = pc; 1 = data; 2 = {28'h0, state}; 3 = {pc[15:0], data[15:0]}.
REQ-017 SHALL run a refresh counter 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and the digit index advances 0..7, wrapping 7->0.
REQ-018 SHALL load a 32-bit snapshot of the selected view word in the cycle where refresh counter = 0 and digit index = 0, so one full 8-digit scan shows one coherent value.
REQ-019 SHALL register an, seg and dp, with one cycle of latency from digit index/snapshot to outputs.
REQ-020 SHALL drive an = ~(1 << index), with seg = hex glyph of snapshot nibble [4*index+3 : 4*index].
REQ-021 SHALL use glyphs 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).
REQ-022 SHALL drive dp = 0 only on digit 4 while view = 3 (halfword separator); otherwise dp = 1.
REQ-023 SHALL apply a view change to the display at the next snapshot load, never mid-scan.
REQ-024 SHALL keep the pc, data and state inputs unregistered except by the snapshot.

Reset
REQ-025 SHALL, while rst = 0, force refresh counter = 0, index = 0, view = 0, snapshot = 0, debounce count = 0, accepted level = 0, an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-026 SHALL abandon any in-progress debounce and any partial scan on reset assertion; no press is registered across reset.
REQ-027 SHALL, on the first edge after rst deasserts, load the snapshot; the next edge drives an = 8'hFE.

Configuration
REQ-028 SHALL honour macro BLANK_LEADING_ZEROS_EN: when defined, digits above the most significant non-zero nibble of the snapshot are blanked (an bit = 1, seg = 7'h7F); digit 0 is always shown; snapshot 0 shows a single "0".
REQ-029 SHALL, when BLANK_LEADING_ZEROS_EN is undefined, show all 8 digits, including leading zeros.

Verification (bench uses REFRESH_DIV = 4, DEBOUNCE_CYCLES = 8)
REQ-030 SHALL cover: reset release, pc = 32'h0040_0010 -> an cycles FE,FD,...,7F every 4 cycles; digit 0 seg = 40, digit 1 seg = 79, digit 4 seg = 40, digit 6 seg = 40.
REQ-031 SHALL cover: view_btn high for 12 cycles -> view 0->1 once; high for 5 cycles then low -> view unchanged.
REQ-032 SHALL cover: four clean presses -> view 1,2,3,0 (wrap); with view = 3, pc = 32'h1234, data = 32'hABCD -> digits show 1234ABCD, dp = 0 only when an = 8'hEF.
REQ-033 SHALL cover: data changes from 32'h1 to 32'hF mid-scan in view 1 -> remaining digits of the current scan unchanged; digit 0 shows 0E only on the next scan.
REQ-034 SHALL cover: rst pulsed low during a press and mid-scan -> outputs go to FF/7F/1 immediately (async); view = 0 after release.
REQ-035 SHALL cover, with BLANK_LEADING_ZEROS_EN: state = 4'h5 in view 2 -> only digit 0 enabled, seg = 12; without the macro, all 8 digits are enabled.
